// File: rtl/rr_decode_arbiter.sv
// rr_decode_arbiter
//   Round-robin arbiter for one shared resource. The resource is enabled through a
//   3-to-8 one-hot decoder. The arbiter picks one requester, drives the decoder
//   select/enable and a registered one-hot grant, and holds the grant until the
//   owner signals done, drops its request, or the hold timer expires.
// Parameters
//   NUM_REQ   number of requesters (2**IDX_W)
//   IDX_W     width of grant_idx
//   MAX_HOLD  max cycles one grant is held; 0 = no limit
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   req        request lines, bit k = requester k
//   done       current owner releases the resource (ignored while idle)
//   grant_en   grant active, drives the decoder enable
//   grant_idx  index of the current owner, drives the decoder select
//   grant      one-hot grant, 1<<grant_idx while grant_en=1, else 0
//   timeout    one-cycle pulse when the hold timer revokes a grant
module rr_decode_arbiter #(
  parameter int unsigned NUM_REQ  = 8,
  parameter int unsigned IDX_W    = 3,
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               done,
  output logic               grant_en,
  output logic [IDX_W-1:0]   grant_idx,
  output logic [NUM_REQ-1:0] grant,
  output logic               timeout
);

  localparam int unsigned HOLD_W    = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam int unsigned HOLD_LAST = (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic                 grant_en_q, grant_en_d;
  logic [IDX_W-1:0]     grant_idx_q, grant_idx_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic                 timeout_q, timeout_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [HOLD_W-1:0]    hold_cnt_q, hold_cnt_d;

  logic                 found;
  logic [IDX_W-1:0]     winner;
  logic [IDX_W-1:0]     cand;
  logic                 hold_hit;
  logic                 owner_req;

  // Winner search: walk from ptr upward; the IDX_W-bit add wraps modulo NUM_REQ.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = ptr_q + IDX_W'(i);
      if (!found && req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_comb begin
    owner_req = req[grant_idx_q];
    hold_hit  = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_W'(HOLD_LAST));

    state_d     = state_q;
    grant_en_d  = grant_en_q;
    grant_idx_d = grant_idx_q;
    grant_d     = grant_q;
    timeout_d   = 1'b0;
    ptr_d       = ptr_q;
    hold_cnt_d  = hold_cnt_q;

    case (state_q)
      IDLE: begin
        grant_en_d = 1'b0;
        grant_d    = '0;
        if (found) begin
          state_d     = GRANT;
          grant_en_d  = 1'b1;
          grant_idx_d = winner;
          grant_d     = NUM_REQ'(1) << winner;
          hold_cnt_d  = '0;
        end
      end
      GRANT: begin
        if (done || !owner_req || hold_hit) begin
          // Timeout flags only a release the timer caused, not one done/drop also caused.
          timeout_d  = !done && owner_req && hold_hit;
          state_d    = IDLE;
          grant_en_d = 1'b0;
          grant_d    = '0;
          ptr_d      = grant_idx_q + IDX_W'(1);
          hold_cnt_d = '0;
        end else if (MAX_HOLD != 0 && !hold_hit) begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      grant_en_q  <= 1'b0;
      grant_idx_q <= '0;
      grant_q     <= '0;
      timeout_q   <= 1'b0;
      ptr_q       <= '0;
      hold_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      grant_en_q  <= grant_en_d;
      grant_idx_q <= grant_idx_d;
      grant_q     <= grant_d;
      timeout_q   <= timeout_d;
      ptr_q       <= ptr_d;
      hold_cnt_q  <= hold_cnt_d;
    end
  end

  assign grant_en  = grant_en_q;
  assign grant_idx = grant_idx_q;
  assign grant     = grant_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_decode_arbiter.sv
// tb_rr_decode_arbiter
//   Drives directed scenarios and randomized traffic into rr_decode_arbiter.
//   A reference model pushes the expected outputs of every cycle into a queue;
//   an independent monitor pops and compares after each rising edge.
module tb_rr_decode_arbiter;

  localparam int NREQ = 8;
  localparam int HOLD = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req = '0;
  logic       done = 1'b0;
  logic       grant_en;
  logic [2:0] grant_idx;
  logic [7:0] grant;
  logic       timeout;

  rr_decode_arbiter #(.NUM_REQ(8), .IDX_W(3), .MAX_HOLD(HOLD)) dut (
    .clk(clk), .rst(rst), .req(req), .done(done),
    .grant_en(grant_en), .grant_idx(grant_idx), .grant(grant), .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic [2:0] idx;
    logic [7:0] g;
    logic       to;
  } exp_t;

  exp_t expq[$];
  int   checks = 0;
  int   failures = 0;

  // Reference model: owner=-1 means nobody holds the resource.
  int m_owner = -1;
  int m_idx   = 0;
  int m_ptr   = 0;
  int m_held  = 0;   // cycles the current grant has been visible
  int m_to    = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  task automatic model_step(input logic r, input logic [7:0] rq, input logic d);
    bit found;
    if (r) begin
      m_owner = -1; m_idx = 0; m_ptr = 0; m_held = 0; m_to = 0;
    end else if (m_owner < 0) begin
      m_to = 0;
      found = 0;
      for (int k = 0; k < NREQ; k++) begin
        int c;
        c = (m_ptr + k) % NREQ;
        if (!found && rq[c]) begin
          found = 1; m_owner = c; m_idx = c; m_held = 1;
        end
      end
    end else begin
      bit expired;
      m_to = 0;
      expired = (HOLD != 0) && (m_held == HOLD);
      if (d || !rq[m_owner] || expired) begin
        m_to = (!d && rq[m_owner] && expired) ? 1 : 0;
        m_ptr = (m_owner + 1) % NREQ;
        m_owner = -1;
        m_held = 0;
      end else begin
        m_held++;
      end
    end
  endtask

  // Observation window used by the hold-timer scenario.
  bit obs_en = 0;
  int obs_g04 = 0;
  int obs_to = 0;

  task automatic cyc(input logic r, input logic [7:0] rq, input logic d);
    exp_t e;
    @(negedge clk);
    if (obs_en) begin
      if (grant == 8'h04) obs_g04++;
      if (timeout) obs_to++;
    end
    rst = r; req = rq; done = d;
    model_step(r, rq, d);
    e.en  = (m_owner >= 0);
    e.idx = 3'(m_idx);
    e.g   = (m_owner >= 0) ? (8'(1) << m_owner) : 8'h00;
    e.to  = (m_to != 0);
    expq.push_back(e);
  endtask

  // Monitor: the DUT presents a registered output every cycle.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        check("grant_en",  32'(grant_en),  32'(e.en));
        check("grant_idx", 32'(grant_idx), 32'(e.idx));
        check("grant",     32'(grant),     32'(e.g));
        check("timeout",   32'(timeout),   32'(e.to));
      end
    end
  end

  // Continuous decoder invariant, sampled mid-cycle once reset has been applied.
  bit inv_on = 0;
  always @(negedge clk) begin
    if (inv_on) begin
      logic [7:0] want;
      want = grant_en ? (8'(1) << grant_idx) : 8'h00;
      check("onehot_invariant", 32'(grant), 32'(want));
      assert (grant === want);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rq;
    logic       d;
    logic       r;

    // 1. reset then idle
    repeat (2) cyc(1, 8'h00, 0);
    inv_on = 1;
    repeat (5) cyc(0, 8'h00, 0);

    // 2. single requester, done in cycle 3
    repeat (3) cyc(0, 8'h01, 0);
    cyc(0, 8'h01, 1);
    repeat (3) cyc(0, 8'h00, 0);

    // 3. all requesting, done held -> 0..7,0 each separated by an idle cycle
    cyc(1, 8'h00, 0);
    repeat (18) cyc(0, 8'hFF, 1);
    repeat (2) cyc(0, 8'h00, 0);

    // 4. wrap from ptr=7: grant 6 first, then 0x81 gives 7 then 0
    cyc(1, 8'h00, 0);
    cyc(0, 8'h40, 0);
    cyc(0, 8'h40, 1);
    repeat (5) cyc(0, 8'h81, 1);
    repeat (2) cyc(0, 8'h00, 0);

    // 5. hold timer: 16 grant cycles, one timeout pulse, regrant after one idle cycle
    obs_en = 1;
    repeat (18) cyc(0, 8'h04, 0);
    obs_en = 0;
    check("hold_cycles", 32'(obs_g04), 32'd16);
    check("timeout_pulses", 32'(obs_to), 32'd1);
    repeat (3) cyc(0, 8'h04, 0);
    repeat (2) cyc(0, 8'h00, 0);

    // 6. reset mid-grant, then 0x11 must go to 0
    repeat (3) cyc(0, 8'h10, 0);
    cyc(1, 8'h10, 0);
    repeat (3) cyc(0, 8'h11, 0);
    repeat (2) cyc(0, 8'h00, 0);

    // Randomized traffic: slowly changing request masks, sporadic done, rare reset.
    rq = 8'($urandom);
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 7) == 0) rq = 8'($urandom);
      if ($urandom_range(0, 11) == 0) rq[$urandom_range(0, 7)] ^= 1'b1;
      d = ($urandom_range(0, 5) == 0);
      r = ($urandom_range(0, 299) == 0);
      cyc(r, rq, d);
    end
    cyc(0, 8'h00, 0);

    begin
      int waited;
      waited = 0;
      while (expq.size() > 0 && waited < 10) begin
        @(posedge clk);
        #2;
        waited++;
      end
      check("scoreboard_drained", 32'(expq.size()), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
